// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer, LSB first; the word appears on data_out at the edge its last bit is accepted.
// The output register holds one word; a word completing while that register is still full is dropped and flagged in overrun.
module sipo_deserializer #(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serial_in,
   input  logic                 bit_valid,
   input  logic                 sync,
   output logic [N-1:0]         data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic [$clog2(N)-1:0] bit_count,
   output logic                 overrun,
   input  logic                 clear_ovr
);

   localparam int BCW = $clog2(N);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(N - 1);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t         state_q, state_d;
   logic [BCW-1:0] bit_count_q, bit_count_d;
   logic [N-1:0]   shreg_q, shreg_d;
   logic [N-1:0]   data_out_q, data_out_d;
   logic           data_valid_q, data_valid_d;
   logic           overrun_q, overrun_d;
   logic [N-1:0]   first_bit;
   logic [N-1:0]   word;
   logic           word_done;

   always_comb begin
      state_d      = state_q;
      bit_count_d  = bit_count_q;
      shreg_d      = shreg_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      overrun_d    = overrun_q;
      word_done    = 1'b0;
      first_bit    = {{(N-1){1'b0}}, serial_in};
      // Bits above bit_count are always zero, so OR-ing in the new bit is enough.
      word         = shreg_q | (first_bit << bit_count_q);

      if (sync) begin
         shreg_d     = bit_valid ? first_bit : '0;
         bit_count_d = bit_valid ? BCW'(1) : '0;
         state_d     = bit_valid ? COLLECT : IDLE;
      end else if (bit_valid) begin
         case (state_q)
            IDLE: begin
               shreg_d     = first_bit;
               bit_count_d = BCW'(1);
               state_d     = COLLECT;
            end
            COLLECT: begin
               if (bit_count_q == LAST_BIT) begin
                  word_done   = 1'b1;
                  shreg_d     = '0;
                  bit_count_d = '0;
                  state_d     = IDLE;
               end else begin
                  shreg_d     = word;
                  bit_count_d = bit_count_q + BCW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (word_done && (!data_valid_q || data_ready)) begin
         data_out_d   = word;
         data_valid_d = 1'b1;
      end else if (data_valid_q && data_ready) begin
         data_valid_d = 1'b0;
      end

      // A drop on the same edge as a clear wins, so no overrun is ever lost.
      if (clear_ovr) begin
         overrun_d = 1'b0;
      end
      if (word_done && data_valid_q && !data_ready) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         bit_count_q  <= '0;
         shreg_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_count_q  <= bit_count_d;
         shreg_q      <= shreg_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign bit_count  = bit_count_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (N=8): vector table plus hand-written async reset sequence.
module tb_sipo_deserializer;

   logic       clk;
   logic       reset;
   logic       serial_in;
   logic       bit_valid;
   logic       sync;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic [2:0] bit_count;
   logic       overrun;
   logic       clear_ovr;

   int checks = 0;
   int passed = 0;

   sipo_deserializer #(.N(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .serial_in  (serial_in),
      .bit_valid  (bit_valid),
      .sync       (sync),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .bit_count  (bit_count),
      .overrun    (overrun),
      .clear_ovr  (clear_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       bv, si, sy, rdy, clr;
      logic [7:0] edo;
      logic       edv;
      logic [2:0] ebc;
      logic       eov;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic bv, si, sy, rdy, clr,
                      input logic [7:0] edo, input logic edv,
                      input logic [2:0] ebc, input logic eov);
      vec_t v;
      v.bv = bv; v.si = si; v.sy = sy; v.rdy = rdy; v.clr = clr;
      v.edo = edo; v.edv = edv; v.ebc = ebc; v.eov = eov;
      vq.push_back(v);
   endtask

   // Eight back-to-back bits of w; mid rows expect the held output, the last row the final one.
   task automatic add_word(input logic [7:0] w, input logic mid_rdy, last_rdy, last_clr,
                           input logic [7:0] mid_do, input logic mid_dv, mid_ov,
                           input logic [7:0] fin_do, input logic fin_dv, fin_ov);
      for (int i = 0; i < 7; i++)
         add(1'b1, w[i], 1'b0, mid_rdy, 1'b0, mid_do, mid_dv, 3'(i + 1), mid_ov);
      add(1'b1, w[7], 1'b0, last_rdy, last_clr, fin_do, fin_dv, 3'd0, fin_ov);
   endtask

   task automatic drive(input logic bv, si, sy, rdy, clr);
      bit_valid = bv; serial_in = si; sync = sy; data_ready = rdy; clear_ovr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] edo, input logic edv,
                        input logic [2:0] ebc, input logic eov);
      checks++;
      if (data_out === edo && data_valid === edv && bit_count === ebc && overrun === eov)
         passed++;
      else
         $display("FAIL %s: got data_out=%h data_valid=%b bit_count=%0d overrun=%b, expected %h %b %0d %b",
                  name, data_out, data_valid, bit_count, overrun, edo, edv, ebc, eov);
   endtask

   initial begin
      logic [7:0] c3;
      logic [7:0] w55;
      logic [7:0] w96;
      c3  = 8'hC3;
      w55 = 8'h55;
      w96 = 8'h96;

      // 0x4D, consumer always ready, then consumed
      add_word(8'h4D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h4D, 1'b1, 1'b0);
      add(0, 0, 0, 1, 0, 8'h4D, 1'b0, 3'd0, 1'b0);
      // 0xA5 held, 0x3C dropped -> overrun, then clear, then consume
      add_word(8'hA5, 1'b0, 1'b0, 1'b0, 8'h4D, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
      add_word(8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
      add(0, 0, 0, 0, 1, 8'hA5, 1'b1, 3'd0, 1'b0);
      add(0, 0, 0, 1, 0, 8'hA5, 1'b0, 3'd0, 1'b0);
      // clear_ovr on the same edge as a drop leaves overrun set
      add_word(8'h11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0);
      add_word(8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
      add(0, 0, 0, 0, 1, 8'h11, 1'b1, 3'd0, 1'b0);
      add(0, 0, 0, 1, 0, 8'h11, 1'b0, 3'd0, 1'b0);
      // three ones, sync without a bit, then 0x0F
      for (int k = 1; k <= 3; k++) add(1, 1, 0, 0, 0, 8'h11, 1'b0, 3'(k), 1'b0);
      add(0, 1, 1, 0, 0, 8'h11, 1'b0, 3'd0, 1'b0);
      add_word(8'h0F, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0);
      add(0, 0, 0, 1, 0, 8'h0F, 1'b0, 3'd0, 1'b0);
      // sync with bit 7: no completion, the bit starts a new word -> 0x01
      for (int k = 1; k <= 7; k++) add(1, 1, 0, 0, 0, 8'h0F, 1'b0, 3'(k), 1'b0);
      add(1, 1, 1, 0, 0, 8'h0F, 1'b0, 3'd1, 1'b0);
      for (int k = 2; k <= 7; k++) add(1, 0, 0, 0, 0, 8'h0F, 1'b0, 3'(k), 1'b0);
      add(1, 0, 0, 0, 0, 8'h01, 1'b1, 3'd0, 1'b0);
      add(0, 0, 0, 1, 0, 8'h01, 1'b0, 3'd0, 1'b0);
      // 0xC3 with bit_valid toggling; serial_in inverted on idle cycles
      for (int i = 0; i < 8; i++) begin
         add(1, c3[i], 0, 0, 0, (i == 7) ? 8'hC3 : 8'h01, i == 7, (i == 7) ? 3'd0 : 3'(i + 1), 1'b0);
         add(0, ~c3[i], 0, 0, 0, (i == 7) ? 8'hC3 : 8'h01, i == 7, (i == 7) ? 3'd0 : 3'(i + 1), 1'b0);
      end
      add(0, 0, 0, 1, 0, 8'hC3, 1'b0, 3'd0, 1'b0);
      // 0x7E pending, consumed on the edge 0x81 completes
      add_word(8'h7E, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 8'h7E, 1'b1, 1'b0);
      add_word(8'h81, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0);
      add(0, 0, 0, 1, 0, 8'h81, 1'b0, 3'd0, 1'b0);

      reset = 1'b1;
      bit_valid = 0; serial_in = 0; sync = 0; data_ready = 0; clear_ovr = 0;
      #3;
      check("reset_async", 8'h00, 1'b0, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      check("reset_held", 8'h00, 1'b0, 3'd0, 1'b0);
      reset = 1'b0;

      foreach (vq[r]) begin
         drive(vq[r].bv, vq[r].si, vq[r].sy, vq[r].rdy, vq[r].clr);
         check($sformatf("row%0d", r), vq[r].edo, vq[r].edv, vq[r].ebc, vq[r].eov);
      end

      // Async reset mid-word with a pending output word
      for (int i = 0; i < 8; i++) drive(1'b1, w55[i], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("pre_reset", 8'h55, 1'b1, 3'd5, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("reset_midop", 8'h00, 1'b0, 3'd0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) drive(1'b1, w96[i], 1'b0, 1'b1, 1'b0);
      check("after_reset_word", 8'h96, 1'b1, 3'd0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter N, default 8, word width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port serial_in  input  1  serial data bit, LSB of each word first.
REQ-005 SHALL have port bit_valid  input  1  serial_in is sampled only on edges where bit_valid=1.
REQ-006 SHALL have port sync  input  1  word-boundary realign strobe; discards any partial word.
REQ-007 SHALL have port data_out  output  N  last completed word.
REQ-008 SHALL have port data_valid  output  1  data_out holds an unconsumed word.
REQ-009 SHALL have port data_ready  input  1  consumer accepts data_out on edges where data_valid=1 and data_ready=1.
REQ-010 SHALL have port bit_count  output  $clog2(N)  bits accepted into the current partial word.
REQ-011 SHALL have port overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 SHALL have port clear_ovr  input  1  synchronous clear of overrun.

Function
REQ-013 SHALL implement states IDLE (bit_count=0, no partial word) and COLLECT (1..N-1 bits held).
REQ-014 SHALL in IDLE move to COLLECT on an edge with bit_valid=1, storing that bit as word bit 0 and setting bit_count=1.
REQ-015 SHALL in COLLECT store the accepted bit at position bit_count and increment bit_count; bit_valid=0 holds all collection state.
REQ-016 SHALL on the edge accepting bit N-1 complete the word, return to IDLE and set bit_count=0.
REQ-017 SHALL on word completion load the word into data_out and set data_valid=1 at that same edge (zero extra latency) when data_valid=0 or data_ready=1 at that edge.
REQ-018 SHALL on word completion with data_valid=1 and data_ready=0 discard the new word, leave data_out/data_valid unchanged, and set overrun=1.
REQ-019 SHALL clear data_valid at an edge with data_valid=1, data_ready=1 and no word completing; data_out retains its value.
REQ-020 SHALL hold data_out stable while data_valid=1 until the handshake edge.
REQ-021 SHALL on sync=1 discard the partial word and clear bit_count; if bit_valid=1 on the same edge, that bit becomes bit 0 of a new word (state COLLECT, bit_count=1); otherwise state IDLE.
REQ-022 SHALL give sync priority over word completion: a bit N-1 arriving with sync=1 starts a new word instead of completing one.
REQ-023 SHALL not affect data_out, data_valid or the output handshake by sync.
REQ-024 SHALL keep overrun=1 until an edge with clear_ovr=1; if clear_ovr=1 and an overrun occurs at the same edge, overrun SHALL end at 1.
REQ-025 SHALL accept back-to-back bits (bit_valid=1 every cycle) with no bubbles, one word per N cycles.

Reset
REQ-026 SHALL on reset=1, immediately and independent of clk, force state IDLE, bit_count=0, partial word=0, data_out=0, data_valid=0, overrun=0.
REQ-027 SHALL discard a partial word and a pending output word when reset asserts mid-operation; first accepted bit after deassertion is bit 0.

Verification
REQ-028 SHALL cover: N=8, bits 1,0,1,1,0,0,1,0 on consecutive cycles, data_ready=1 -> data_out=8'h4D, data_valid=1 for one cycle at the edge of bit 7.
REQ-029 SHALL cover: word 8'hA5 then word 8'h3C back-to-back with data_ready=0 -> data_out stays 8'hA5, data_valid=1, overrun=1; clear_ovr pulse -> overrun=0.
REQ-030 SHALL cover: 3 bits of 1 then sync with bit_valid=0, then bits of 8'h0F -> data_out=8'h0F, no overrun.
REQ-031 SHALL cover: bit_valid toggling 1/0 every cycle for word 8'hC3 -> data_out=8'hC3 after 16 cycles, bit_count holding on idle cycles.
REQ-032 SHALL cover: reset asserted asynchronously between edges with bit_count=5 and data_valid=1 -> all outputs 0 before the next clk edge.
REQ-033 SHALL cover: data_ready=1 on the edge word 8'h81 completes while data_valid=1 holds 8'h7E -> 8'h7E consumed, data_out=8'h81, data_valid=1, overrun=0.
